// File: rtl/l1_dcache_ctrl.sv
// l1_dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache.
// Hits on the CPU side are answered combinationally in IDLE. Misses evict a
// dirty victim first (WRITEBACK), then fetch the requested line (ALLOCATE).
// After the fill, the held request hits on the following cycle.
module l1_dcache_ctrl #(
  parameter int SET_BITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int TAG_W    = 12 - SET_BITS;
  localparam int NUM_SETS = 1 << SET_BITS;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]          state;
  logic [127:0]        data_array [NUM_SETS];
  logic [TAG_W-1:0]    tag_array  [NUM_SETS];
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;

  logic [TAG_W-1:0]    req_tag;
  logic [SET_BITS-1:0] idx;
  logic [2:0]          word_sel;
  logic [127:0]        cur_line;
  logic [15:0]         cur_word;
  logic                request;
  logic                hit;
  logic                addr_lsb_unused;

  // Split the CPU address into tag / index / word select and look up the set.
  always_comb begin
    req_tag         = mem_address[15:4+SET_BITS];
    idx             = mem_address[3+SET_BITS:4];
    word_sel        = mem_address[3:1];
    addr_lsb_unused = mem_address[0];
    cur_line        = data_array[idx];
    cur_word        = cur_line[{word_sel, 4'h0} +: 16];
    request         = mem_read | mem_write;
    hit             = valid[idx] && (tag_array[idx] == req_tag);
  end

  // Drive CPU and memory outputs purely from state so they drop the instant reset hits.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = 128'h0;
    case (state)
      IDLE: begin
        if (request && hit) begin
          mem_resp  = 1'b1;
          mem_rdata = cur_word;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_array[idx], idx, 4'h0};
        pmem_wdata   = cur_line;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, 4'h0};
      end
      default: begin
        mem_resp = 1'b0;
      end
    endcase
  end

  // Controller state plus per-line valid/dirty bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            if (hit) begin
              if (mem_write) begin
                dirty[idx] <= 1'b1;
              end
            end else if (valid[idx] && dirty[idx]) begin
              state <= WRITEBACK;
            end else begin
              state <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty[idx] <= 1'b0;
            state      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line data and tags: filled from memory on ALLOCATE completion, byte-merged on write hits.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && pmem_resp) begin
      data_array[idx] <= pmem_rdata;
      tag_array[idx]  <= req_tag;
    end else if (state == IDLE && request && hit && mem_write) begin
      if (mem_byte_enable[0]) begin
        data_array[idx][{word_sel, 4'h0} +: 8] <= mem_wdata[7:0];
      end
      if (mem_byte_enable[1]) begin
        data_array[idx][{word_sel, 4'h8} +: 8] <= mem_wdata[15:8];
      end
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// tb_l1_dcache_ctrl: directed scenarios for the L1 data cache controller.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_l1_dcache_ctrl;

  logic         clk;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int total_checks;
  int passed_checks;

  localparam logic [127:0] LINE1 = {16'h7E7E, 16'h6666, 16'h5555, 16'h4444,
                                    16'h3333, 16'h2222, 16'h5678, 16'h1234};
  localparam logic [127:0] LINE1_MOD = {16'h7E7E, 16'h6666, 16'h5555, 16'h4444,
                                        16'h3333, 16'h2222, 16'hAB78, 16'h1234};
  localparam logic [127:0] LINE2 = {16'h2007, 16'h2006, 16'h2005, 16'h2004,
                                    16'h2003, 16'h2002, 16'h2001, 16'hBEEF};
  localparam logic [127:0] LINE3 = {16'h3007, 16'h3006, 16'h3005, 16'h3004,
                                    16'h3003, 16'h3002, 16'h9911, 16'h0C0C};
  localparam logic [127:0] LINE3_MOD = {16'h3007, 16'h3006, 16'h3005, 16'h3004,
                                        16'h3003, 16'h3002, 16'h99CD, 16'h0C0C};
  localparam logic [127:0] LINE4 = {16'h4007, 16'h4006, 16'h4005, 16'h4004,
                                    16'h4003, 16'h4002, 16'h4001, 16'h4A4A};

  l1_dcache_ctrl #(.SET_BITS(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  // 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    mem_address = 16'h0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_wdata = 16'h0;
    pmem_rdata = 128'h0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000)
      $display("FAIL reset_ctrl: got %b expected 000", {mem_resp, pmem_read, pmem_write});
    else passed_checks++;
    total_checks++;
    if ({mem_rdata, pmem_address, pmem_wdata} !== 160'h0)
      $display("FAIL reset_data: got %h expected 0", {mem_rdata, pmem_address, pmem_wdata});
    else passed_checks++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_read_miss();
    @(negedge clk);
    mem_address = 16'h0010; mem_read = 1'b1;
    #1;
    total_checks++;
    if ({mem_resp, pmem_read} !== 2'b00)
      $display("FAIL miss_first_cycle: got %b expected 00", {mem_resp, pmem_read});
    else passed_checks++;
    @(negedge clk); #1;
    total_checks++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h0010})
      $display("FAIL alloc_req: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=0010",
               pmem_read, pmem_write, pmem_address);
    else passed_checks++;
    pmem_rdata = LINE1; pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total_checks++;
    if ({mem_resp, pmem_read, mem_rdata} !== {2'b10, 16'h1234})
      $display("FAIL miss_complete: got resp=%b prd=%b data=%h expected resp=1 prd=0 data=1234",
               mem_resp, pmem_read, mem_rdata);
    else passed_checks++;
  endtask

  task automatic test_read_hit();
    @(negedge clk);
    mem_address = 16'h001E; mem_read = 1'b1;
    #1;
    total_checks++;
    if ({mem_resp, pmem_read, pmem_write, mem_rdata} !== {3'b100, 16'h7E7E})
      $display("FAIL hit_word7: got resp=%b prd=%b pwr=%b data=%h expected resp=1 prd=0 pwr=0 data=7e7e",
               mem_resp, pmem_read, pmem_write, mem_rdata);
    else passed_checks++;
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    mem_address = 16'h0012; mem_read = 1'b0; mem_write = 1'b1;
    mem_byte_enable = 2'b10; mem_wdata = 16'hAB00;
    #1;
    total_checks++;
    if (mem_resp !== 1'b1)
      $display("FAIL write_hit_resp: got %b expected 1", mem_resp);
    else passed_checks++;
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1;
    #1;
    total_checks++;
    if ({mem_resp, mem_rdata} !== {1'b1, 16'hAB78})
      $display("FAIL write_readback: got resp=%b data=%h expected resp=1 data=ab78",
               mem_resp, mem_rdata);
    else passed_checks++;
  endtask

  task automatic test_writeback();
    @(negedge clk);
    mem_address = 16'h0090; mem_read = 1'b1;
    #1;
    total_checks++;
    if ({mem_resp, pmem_write} !== 2'b00)
      $display("FAIL conflict_first_cycle: got %b expected 00", {mem_resp, pmem_write});
    else passed_checks++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total_checks++;
      if ({pmem_write, pmem_read, mem_resp, pmem_address, pmem_wdata} !== {3'b100, 16'h0010, LINE1_MOD})
        $display("FAIL wb_req_%0d: got wr=%b rd=%b resp=%b addr=%h data=%h expected wr=1 rd=0 resp=0 addr=0010 data=%h",
                 i, pmem_write, pmem_read, mem_resp, pmem_address, pmem_wdata, LINE1_MOD);
      else passed_checks++;
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total_checks++;
    if ({pmem_read, pmem_write, mem_resp, pmem_address} !== {3'b100, 16'h0090})
      $display("FAIL wb_then_alloc: got rd=%b wr=%b resp=%b addr=%h expected rd=1 wr=0 resp=0 addr=0090",
               pmem_read, pmem_write, mem_resp, pmem_address);
    else passed_checks++;
    pmem_rdata = LINE2; pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total_checks++;
    if ({mem_resp, mem_rdata} !== {1'b1, 16'hBEEF})
      $display("FAIL wb_final_read: got resp=%b data=%h expected resp=1 data=beef", mem_resp, mem_rdata);
    else passed_checks++;
    // Re-reading the evicted tag must miss without a writeback (fresh line is clean).
    @(negedge clk);
    mem_address = 16'h0010;
    @(negedge clk); #1;
    total_checks++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h0010})
      $display("FAIL reread_clean_miss: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=0010",
               pmem_read, pmem_write, pmem_address);
    else passed_checks++;
    pmem_rdata = LINE1; pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total_checks++;
    if ({mem_resp, mem_rdata} !== {1'b1, 16'h1234})
      $display("FAIL reread_data: got resp=%b data=%h expected resp=1 data=1234", mem_resp, mem_rdata);
    else passed_checks++;
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    mem_address = 16'h0020; mem_read = 1'b1;
    @(negedge clk); #1;
    total_checks++;
    if (pmem_read !== 1'b1)
      $display("FAIL abort_alloc_entered: got %b expected 1", pmem_read);
    else passed_checks++;
    reset = 1'b1;
    #1;
    total_checks++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b00, 16'h0000})
      $display("FAIL abort_immediate: got rd=%b wr=%b addr=%h expected rd=0 wr=0 addr=0000",
               pmem_read, pmem_write, pmem_address);
    else passed_checks++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_checks++;
    if ({mem_resp, pmem_read} !== 2'b00)
      $display("FAIL abort_rereq_idle: got %b expected 00", {mem_resp, pmem_read});
    else passed_checks++;
    @(negedge clk); #1;
    total_checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 16'h0020})
      $display("FAIL abort_miss_again: got rd=%b addr=%h expected rd=1 addr=0020", pmem_read, pmem_address);
    else passed_checks++;
    pmem_rdata = LINE3; pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total_checks++;
    if ({mem_resp, mem_rdata} !== {1'b1, 16'h0C0C})
      $display("FAIL abort_final_read: got resp=%b data=%h expected resp=1 data=0c0c", mem_resp, mem_rdata);
    else passed_checks++;
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    mem_address = 16'h0022; mem_read = 1'b1; mem_write = 1'b1;
    mem_byte_enable = 2'b01; mem_wdata = 16'h00CD;
    #1;
    total_checks++;
    if (mem_resp !== 1'b1)
      $display("FAIL rw_resp: got %b expected 1", mem_resp);
    else passed_checks++;
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    total_checks++;
    if (mem_rdata !== 16'h99CD)
      $display("FAIL rw_low_byte: got %h expected 99cd", mem_rdata);
    else passed_checks++;
    // Conflicting tag must now write the dirty line back.
    @(negedge clk);
    mem_address = 16'h00A0;
    @(negedge clk); #1;
    total_checks++;
    if ({pmem_write, pmem_address, pmem_wdata} !== {1'b1, 16'h0020, LINE3_MOD})
      $display("FAIL rw_dirty_wb: got wr=%b addr=%h data=%h expected wr=1 addr=0020 data=%h",
               pmem_write, pmem_address, pmem_wdata, LINE3_MOD);
    else passed_checks++;
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_rdata = LINE4;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total_checks++;
    if ({mem_resp, mem_rdata} !== {1'b1, 16'h4A4A})
      $display("FAIL rw_refill_read: got resp=%b data=%h expected resp=1 data=4a4a", mem_resp, mem_rdata);
    else passed_checks++;
  endtask

  task automatic test_zero_byte_enable();
    @(negedge clk);
    mem_address = 16'h00A0; mem_read = 1'b0; mem_write = 1'b1;
    mem_byte_enable = 2'b00; mem_wdata = 16'hFFFF;
    #1;
    total_checks++;
    if (mem_resp !== 1'b1)
      $display("FAIL be0_resp: got %b expected 1", mem_resp);
    else passed_checks++;
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1;
    #1;
    total_checks++;
    if (mem_rdata !== 16'h4A4A)
      $display("FAIL be0_unchanged: got %h expected 4a4a", mem_rdata);
    else passed_checks++;
    @(negedge clk);
    mem_address = 16'h0020;
    @(negedge clk); #1;
    total_checks++;
    if ({pmem_write, pmem_address} !== {1'b1, 16'h00A0})
      $display("FAIL be0_sets_dirty: got wr=%b addr=%h expected wr=1 addr=00a0", pmem_write, pmem_address);
    else passed_checks++;
    reset = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_byte_write();
    test_writeback();
    test_reset_mid_miss();
    test_read_write_both();
    test_zero_byte_enable();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
